forwarding_stall_unit: RTL

FORWARDING_STALL_UNIT -- requirements
Module: forwarding_stall_unit

---
 rtl/forwarding_stall_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/forwarding_stall_unit.sv
// Operand forwarding select and load-use stall control for a 5-stage pipeline.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module forwarding_stall_unit #(
    parameter int ADDR_W            = 5,
    parameter int NUM_SRC           = 2,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic [ADDR_W-1:0]         idex_rd,
    input  logic                      idex_reg_write,
    input  logic                      idex_mem_read,
    input  logic [ADDR_W-1:0]         exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel_ex,
    output logic                      stall,
    output logic                      pc_we,
    output logic                      ifid_we,
    output logic                      idex_bubble,
    output logic [15:0]               stall_cnt
);

    typedef enum logic {IDLE, STALL} state_t;

    // The hazard cycle itself is the first bubble, so STALL covers the remaining ones.
    localparam logic [1:0] CNT_LOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    state_t               state, state_nxt;
    logic [1:0]           cnt, cnt_nxt;
    logic [NUM_SRC-1:0]   hit_idex;
    logic [NUM_SRC-1:0]   hit_exmem;
    logic [2*NUM_SRC-1:0] sel_nxt;
    logic                 hazard;
    logic                 squash;

    assign squash = stall | flush;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ADDR_W-1:0] addr;
        logic              live;
        assign addr         = id_src_addr[g*ADDR_W +: ADDR_W];
        assign live         = id_src_valid[g] && (addr != '0);
        assign hit_idex[g]  = live && idex_reg_write && (idex_rd == addr);
        assign hit_exmem[g] = live && exmem_reg_write && (exmem_rd == addr);
        assign sel_nxt[2*g +: 2] = squash                         ? 2'b00 :
                                   (hit_idex[g] && !idex_mem_read) ? 2'b10 :
                                   hit_exmem[g]                    ? 2'b01 : 2'b00;
    end

    assign hazard      = idex_mem_read && (|hit_idex);
    assign stall       = !flush && (((state == IDLE) && hazard) || (state == STALL));
    assign pc_we       = !stall;
    assign ifid_we     = !stall;
    assign idex_bubble = stall | flush;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0) state_nxt = IDLE;
                    else             cnt_nxt   = cnt - 2'd1;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            fwd_sel_ex <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            fwd_sel_ex <= sel_nxt;
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                             stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
